// File: rtl/cpu_ready_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ready_ctrl_if
// Brief    : CPU RDY / halt / MARIA DMA handshake bundle.
// Revision : 1.0
// ============================================================================
interface cpu_ready_ctrl_if;
    logic cpu_ce;
    logic deassert_ready;
    logic line_start;
    logic dma_req;
    logic dma_done;
    logic rdy;
    logic halt_b;
    logic dma_grant;
    logic wsync_pending;

    // The system side drives the strobes and requests.
    modport master (
        output cpu_ce,
        output deassert_ready,
        output line_start,
        output dma_req,
        output dma_done,
        input  rdy,
        input  halt_b,
        input  dma_grant,
        input  wsync_pending
    );

    // The controller side samples the strobes and owns the stall outputs.
    modport slave (
        input  cpu_ce,
        input  deassert_ready,
        input  line_start,
        input  dma_req,
        input  dma_done,
        output rdy,
        output halt_b,
        output dma_grant,
        output wsync_pending
    );
endinterface
`default_nettype wire

// File: rtl/cpu_ready_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ready_ctrl
// Brief    : CPU RDY generation from WSYNC stalls and MARIA DMA bus hand-off.
// Revision : 1.0
// ============================================================================
module cpu_ready_ctrl #(
    parameter int HALT_DELAY = 2
) (
    input  wire logic        sysclock,
    input  wire logic        reset_b,
    cpu_ready_ctrl_if.slave  bus
);

    localparam logic [2:0] c_HALT_DELAY   = 3'(HALT_DELAY);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_HALT_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DMA       = 2'd2;
    localparam logic [1:0] c_ST_RELEASE   = 2'd3;

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic       r_dr_prev;
    logic       r_wsync_pending;
    logic       r_halt_b;
    logic       r_dma_grant;
    logic       r_rdy;

    logic [1:0] w_state_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_wsync_edge;
    logic       w_wsync_nxt;
    logic       w_halt_b_nxt;
    logic       w_grant_nxt;

    // A held WSYNC write level counts as a single request.
    assign w_wsync_edge = bus.deassert_ready & ~r_dr_prev;

    always_comb begin
        w_wsync_nxt = r_wsync_pending;
        if (w_wsync_edge) begin
            w_wsync_nxt = 1'b1;
        end else if (bus.line_start) begin
            w_wsync_nxt = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.dma_req) begin
                    w_state_nxt = c_ST_HALT_REQ;
                    w_cnt_nxt   = c_HALT_DELAY;
                end
            end
            c_ST_HALT_REQ: begin
                if (!bus.dma_req) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (bus.cpu_ce) begin
                    // Counter saturates at zero; grant on the strobe that empties it.
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = c_ST_DMA;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 3'd1;
                    end
                end
            end
            c_ST_DMA: begin
                if (bus.dma_done) begin
                    w_state_nxt = c_ST_RELEASE;
                end
            end
            c_ST_RELEASE: begin
                if (bus.cpu_ce) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase

        // Grant only exists inside DMA, where halt_b is always low.
        w_halt_b_nxt = (w_state_nxt == c_ST_IDLE);
        w_grant_nxt  = (w_state_nxt == c_ST_DMA);
    end

    always_ff @(posedge sysclock) begin
        if (!reset_b) begin
            r_state         <= c_ST_IDLE;
            r_cnt           <= 3'd0;
            r_dr_prev       <= 1'b0;
            r_wsync_pending <= 1'b0;
            r_halt_b        <= 1'b1;
            r_dma_grant     <= 1'b0;
            r_rdy           <= 1'b1;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_dr_prev       <= bus.deassert_ready;
            r_wsync_pending <= w_wsync_nxt;
            r_halt_b        <= w_halt_b_nxt;
            r_dma_grant     <= w_grant_nxt;
            r_rdy           <= ~w_wsync_nxt & w_halt_b_nxt;
        end
    end

    assign bus.rdy           = r_rdy;
    assign bus.halt_b        = r_halt_b;
    assign bus.dma_grant     = r_dma_grant;
    assign bus.wsync_pending = r_wsync_pending;

endmodule
`default_nettype wire
